lv_pwm_dt_ins: RTL
==================

LV_PWM_DT_INS -- requirements
Module: lv_pwm_dt_ins

Interface
REQ-001 SHALL have parameter CLK_M, default 48, meaning core clock frequency in MHz.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, meaning width of the error counter.
REQ-003 SHALL have port i_clk, input, 1, meaning the single core clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port i_pwm_en, input, 1, meaning the drive enable; low forces both gates off.
REQ-006 SHALL have port i_pwm_h, input, 1, meaning the high-side on request, already synchronous to i_clk.
REQ-007 SHALL have port i_pwm_l, input, 1, meaning the low-side on request, already synchronous to i_clk.
REQ-008 SHALL have port i_dt_cfg, input, 4, meaning the dead-time select index.
REQ-009 SHALL have port i_err_clr, input, 1, meaning a single-cycle clear pulse for o_err_cnt.
REQ-010 SHALL have port o_gate_h, output, 1, meaning the high-side gate command.
REQ-011 SHALL have port o_gate_l, output, 1, meaning the low-side gate command.
REQ-012 SHALL have port o_lv_pwm_dt, output, 1, meaning the shoot-through request flag, a level.
REQ-013 SHALL have port o_dt_busy, output, 1, meaning a dead-time count is in progress.
REQ-014 SHALL have port o_err_cnt, output, ERR_CNT_W, meaning a saturating count of shoot-through events.

Function
REQ-015 SHALL define a dead-time table DT_CYC[i] = ceil(ns_i*CLK_M/1000), where ns_i for i=0..15 is 100,200,400,600,800,1000,1200,1400,1600,1800,2000,2400,2800,3200,3600,4000; at CLK_M=48 this gives DT_CYC[0]=5, DT_CYC[2]=20 and DT_CYC[15]=192.
REQ-016 SHALL register i_pwm_en, i_pwm_h and i_pwm_l once, giving ph, pl and en; the FSM uses only these registered copies.
REQ-017 SHALL implement the FSM states OFF, H_ON, L_ON and ERR.
REQ-018 SHALL decode the outputs from registered state only: o_gate_h=(state==H_ON), o_gate_l=(state==L_ON), o_lv_pwm_dt=(state==ERR).
REQ-019 SHALL, in any state, take ERR at the next edge when en=1 & ph=1 & pl=1; this has priority over all other transitions except en=0.
REQ-020 SHALL take OFF at the next edge from any state when en=0, and hold the dead-time counter at 0 while en=0.
REQ-021 SHALL, on every entry into OFF, clear the dead-time counter to 0 and latch i_dt_cfg into dt_sel; a change to i_dt_cfg while in OFF has no effect until the next OFF entry.
REQ-022 SHALL, in OFF with en=1, increment the counter each cycle, saturating at DT_CYC[dt_sel]-1.
REQ-023 SHALL drive o_dt_busy high whenever state==OFF and counter < DT_CYC[dt_sel]-1.
REQ-024 SHALL make OFF->H_ON when counter==DT_CYC[dt_sel]-1 & ph=1 & pl=0; OFF->L_ON under the same counter condition with pl=1 & ph=0; otherwise stay in OFF.
REQ-025 SHALL, as a result of REQ-022..024, hold both gates low for at least DT_CYC[dt_sel] consecutive cycles between any gate falling and the opposite or same gate rising.
REQ-026 SHALL make H_ON->OFF when ph=0, and L_ON->OFF when pl=0; a change of the opposite request alone with no overlap causes no direct H_ON<->L_ON transition.
REQ-027 SHALL make ERR->OFF only when ph=0 & pl=0; ERR then enters OFF like any other OFF entry (counter cleared, dead time enforced).
REQ-028 SHALL give a turn-off latency of exactly 2 cycles from the i_pwm_* sample edge to the gate output going low.
REQ-029 SHALL increment o_err_cnt on each transition into ERR, saturating at all-ones.
REQ-030 SHALL, when i_err_clr coincides with an ERR entry, set o_err_cnt=1; otherwise i_err_clr sets it to 0.

Reset
REQ-031 SHALL, while i_rst=1 at a clock edge, set state=OFF, counter=0, dt_sel=i_dt_cfg, the input registers=0 and o_err_cnt=0.
REQ-032 SHALL, as a consequence of REQ-031, drive o_gate_h=0, o_gate_l=0, o_lv_pwm_dt=0 and o_dt_busy=1 after reset, so the first turn-on after reset waits a full dead time.
REQ-033 SHALL, on reset asserted mid-operation including ERR, force OFF at that edge with no gate glitch high.

Verification
REQ-034 SHALL cover: CLK_M=48, cfg=0, reset then ph=1 held -> o_gate_h rises 5 cycles after OFF entry, with o_dt_busy high for 4 cycles.
REQ-035 SHALL cover: H_ON, ph 1->0 and pl 0->1 on the same cycle, cfg=2 -> o_gate_h low 2 cycles later, and o_gate_l high exactly 20 cycles after o_gate_h fell.
REQ-036 SHALL cover: ph=pl=1 during H_ON -> o_gate_h low and o_lv_pwm_dt high 2 cycles later, o_err_cnt=1; both released -> 5-cycle dead time (cfg=0) before any gate rises.
REQ-037 SHALL cover: i_dt_cfg changed 15->0 mid-OFF count -> the count still completes at 192.
REQ-038 SHALL cover: 256 ERR entries -> o_err_cnt=255; i_err_clr coincident with an ERR entry -> o_err_cnt=1.
REQ-039 SHALL cover: i_pwm_en=0 during L_ON -> o_gate_l low in 2 cycles; i_rst pulse during ERR -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/lv_pwm_dt_ins.sv
// -----------------------------------------------------------------------------
// lv_pwm_dt_ins
//   Half-bridge gate driver with dead-time insertion and shoot-through
//   detection. The high/low on requests are registered once. A four-state FSM
//   (OFF, H_ON, L_ON, ERR) then decides which gate may be on. Every entry into
//   OFF restarts a dead-time count. The count length is taken from a
//   nanosecond table scaled by the core clock. While ERR is held, both gates
//   stay off and the shoot-through flag is raised.
//
// Parameters
//   CLK_M      core clock frequency in MHz (scales the dead-time table)
//   ERR_CNT_W  width of the saturating shoot-through event counter
//
// Ports
//   i_clk        core clock, rising edge
//   i_rst        synchronous active-high reset
//   i_pwm_en     drive enable; low forces both gates off
//   i_pwm_h      high-side on request (synchronous to i_clk)
//   i_pwm_l      low-side on request (synchronous to i_clk)
//   i_dt_cfg     dead-time select index, latched on each OFF entry
//   i_err_clr    single-cycle clear of o_err_cnt
//   o_gate_h     high-side gate command
//   o_gate_l     low-side gate command
//   o_lv_pwm_dt  shoot-through flag (level, high while in ERR)
//   o_dt_busy    dead-time count in progress
//   o_err_cnt    saturating count of ERR entries
// -----------------------------------------------------------------------------
module lv_pwm_dt_ins #(
   parameter int CLK_M     = 48,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pwm_en,
   input  logic                 i_pwm_h,
   input  logic                 i_pwm_l,
   input  logic [3:0]           i_dt_cfg,
   input  logic                 i_err_clr,
   output logic                 o_gate_h,
   output logic                 o_gate_l,
   output logic                 o_lv_pwm_dt,
   output logic                 o_dt_busy,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   // Dead time in nanoseconds for each select index.
   function automatic int dt_ns(input logic [3:0] sel);
      case (sel)
         4'd0:    return 100;
         4'd1:    return 200;
         4'd2:    return 400;
         4'd3:    return 600;
         4'd4:    return 800;
         4'd5:    return 1000;
         4'd6:    return 1200;
         4'd7:    return 1400;
         4'd8:    return 1600;
         4'd9:    return 1800;
         4'd10:   return 2000;
         4'd11:   return 2400;
         4'd12:   return 2800;
         4'd13:   return 3200;
         4'd14:   return 3600;
         default: return 4000;
      endcase
   endfunction

   // Dead time in clock cycles, rounded up so the hold-off is never shorter
   // than the nanosecond target.
   function automatic int dt_cyc(input logic [3:0] sel);
      return (dt_ns(sel) * CLK_M + 999) / 1000;
   endfunction

   localparam int DT_MAX = dt_cyc(4'd15);
   localparam int CNT_W  = $clog2(DT_MAX + 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_H_ON = 2'd1,
      ST_L_ON = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [3:0]           r_dt_sel;
   logic                 r_en;
   logic                 r_ph;
   logic                 r_pl;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic [CNT_W-1:0]     w_dt_last;
   logic                 w_shoot;
   logic                 w_err_entry;
   logic                 w_off_entry;

   // Last count value of the selected dead time (count runs 0..DT-1).
   assign w_dt_last   = CNT_W'(dt_cyc(r_dt_sel) - 1);

   assign w_shoot     = r_en & r_ph & r_pl;
   assign w_err_entry = w_shoot & (r_state != ST_ERR);

   // Any transition from a non-OFF state into OFF: restarts the dead time
   // and picks up a fresh dead-time select.
   assign w_off_entry = (r_state != ST_OFF) &
                        (~r_en |
                         (~w_shoot &
                          (((r_state == ST_H_ON) & ~r_ph) |
                           ((r_state == ST_L_ON) & ~r_pl) |
                           ((r_state == ST_ERR)  & ~r_ph & ~r_pl))));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_OFF;
         r_cnt     <= '0;
         r_dt_sel  <= i_dt_cfg;
         r_en      <= 1'b0;
         r_ph      <= 1'b0;
         r_pl      <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_en <= i_pwm_en;
         r_ph <= i_pwm_h;
         r_pl <= i_pwm_l;

         // Enable low wins over everything, then shoot-through.
         if (!r_en) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
         end else if (w_shoot) begin
            r_state <= ST_ERR;
         end else begin
            case (r_state)
               ST_OFF: begin
                  if (r_cnt == w_dt_last) begin
                     if (r_ph && !r_pl) begin
                        r_state <= ST_H_ON;
                     end else if (r_pl && !r_ph) begin
                        r_state <= ST_L_ON;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_H_ON: if (!r_ph) r_state <= ST_OFF;
               ST_L_ON: if (!r_pl) r_state <= ST_OFF;
               ST_ERR:  if (!r_ph && !r_pl) r_state <= ST_OFF;
               default: r_state <= ST_OFF;
            endcase
         end

         if (w_off_entry) begin
            r_cnt    <= '0;
            r_dt_sel <= i_dt_cfg;
         end

         // A clear on the same edge as an ERR entry keeps that one event.
         if (i_err_clr) begin
            r_err_cnt <= w_err_entry ? ERR_CNT_W'(1) : '0;
         end else if (w_err_entry && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign o_gate_h    = (r_state == ST_H_ON);
   assign o_gate_l    = (r_state == ST_L_ON);
   assign o_lv_pwm_dt = (r_state == ST_ERR);
   assign o_dt_busy   = (r_state == ST_OFF) && (r_cnt < w_dt_last);
   assign o_err_cnt   = r_err_cnt;

endmodule
